// File: rtl/carregador_disco.sv
// Boot loader: copies words from a combinational disk into instruction memory, one word per READ/WRITE pair.
// Stops on word_count, end of disk, or (optionally) after copying a halt instruction.
module carregador_disco #(
  parameter int          DISK_SIZE    = 16,
  parameter logic [5:0]  HALT_OPCODE  = 6'b011000,
  parameter bit          STOP_ON_HALT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [25:0] mem_base,
  input  logic [25:0] word_count,
  output logic [25:0] disk_addr,
  input  logic [31:0] disk_data,
  output logic [25:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [25:0] words_loaded
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [25:0] DISK_END = 26'(DISK_SIZE);

  state_t      state;
  logic [25:0] base_q;
  logic [25:0] count_q;
  logic [25:0] index;
  logic [31:0] data_q;
  logic [25:0] index_nxt;
  logic        halt_word;
  logic        last_word;

  assign disk_addr = index;
  assign mem_data  = data_q;

  assign index_nxt = index + 26'd1;
  assign halt_word = STOP_ON_HALT && (data_q[31:26] == HALT_OPCODE);
  assign last_word = (index_nxt == count_q) || (index_nxt == DISK_END) || halt_word;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      base_q       <= '0;
      count_q      <= '0;
      index        <= '0;
      data_q       <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q       <= mem_base;
            count_q      <= word_count;
            index        <= '0;
            words_loaded <= '0;
            busy         <= 1'b1;
            if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          // address and data are captured together so both stay frozen under backpressure
          data_q   <= disk_data;
          mem_addr <= base_q + index;
          mem_we   <= 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          if (mem_ready) begin
            mem_we       <= 1'b0;
            words_loaded <= words_loaded + 26'd1;
            index        <= index_nxt;
            if (last_word) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_disco.sv
// Randomized bench for carregador_disco: a list-level model predicts the write sequence and completion timing.
module tb_carregador_disco;

  localparam int         DISK_SIZE = 16;
  localparam logic [5:0] HALT      = 6'b011000;

  logic        clock;
  logic        reset;
  logic        start;
  logic [25:0] mem_base;
  logic [25:0] word_count;
  logic [25:0] disk_addr;
  logic [31:0] disk_data;
  logic [25:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic [25:0] words_loaded;

  logic [31:0] disk [DISK_SIZE];

  int vectors;
  int miscompares;

  carregador_disco dut (
    .clock(clock), .reset(reset), .start(start), .mem_base(mem_base),
    .word_count(word_count), .disk_addr(disk_addr), .disk_data(disk_data),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_ready(mem_ready), .busy(busy), .done(done), .words_loaded(words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    disk_data = 32'h0;
    if (disk_addr < 26'(DISK_SIZE)) disk_data = disk[disk_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // halt_at < 0 means no halt word anywhere in the image
  task automatic fill_disk(input int halt_at);
    for (int i = 0; i < DISK_SIZE; i++) begin
      disk[i] = $urandom;
      if (disk[i][31:26] == HALT) disk[i][26] = ~disk[i][26];
      if (i == halt_at) disk[i][31:26] = HALT;
    end
  endtask

  // mode 0: always ready, 1: 4-cycle stall on the second write, 2: random ready
  task automatic run_load(input logic [25:0] base, input logic [25:0] cnt, input int mode);
    logic [57:0] expq[$];
    logic [57:0] e;
    logic [25:0] paddr;
    logic [31:0] pdata;
    int n, cyc, stalls, wr, bp;
    bit pstall, got_done, rdy;
    for (int i = 0; i < DISK_SIZE && i < int'(cnt); i++) begin
      expq.push_back({base + 26'(i), disk[i]});
      if (disk[i][31:26] == HALT) break;
    end
    n = expq.size();
    @(negedge clock);
    start = 1'b1; mem_base = base; word_count = cnt;
    cyc = 0; stalls = 0; wr = 0; bp = 0; pstall = 0; got_done = 0;
    while (!got_done && cyc < 400) begin
      @(negedge clock);
      cyc++;
      // start is meaningless while busy; garbage here must not disturb the load
      start = 1'($urandom_range(0, 1)); mem_base = $urandom; word_count = $urandom;
      #1;
      if (pstall) begin
        chk("stall_we", mem_we, 1);
        chk("stall_addr", mem_addr, paddr);
        chk("stall_data", mem_data, pdata);
      end
      pstall = 0;
      if (mem_we) begin
        case (mode)
          0: rdy = 1;
          1: rdy = !(wr == 1 && bp < 4);
          default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        mem_ready = rdy;
        if (!rdy) begin
          stalls++;
          if (wr == 1) bp++;
          pstall = 1; paddr = mem_addr; pdata = mem_data;
        end else begin
          chk("disk_addr", disk_addr, wr);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("wr_addr", mem_addr, e[57:32]);
            chk("wr_data", mem_data, e[31:0]);
          end else begin
            chk("write_count", wr + 1, n);
          end
          wr++;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      chk("busy", busy, 1);
      if (done) got_done = 1;
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("done_cycle", cyc, 2 * n + 1 + stalls);
    chk("writes", wr, n);
    chk("words_loaded", words_loaded, n);
    if (mode == 1 && n > 1) chk("bp_cycles", bp, 4);
    @(negedge clock); #1;
    chk("done_low", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_words", words_loaded, n);
    chk("idle_we", mem_we, 0);
  endtask

  task automatic reset_mid_load();
    int writes, guard;
    fill_disk(-1);
    @(negedge clock);
    start = 1'b1; mem_base = $urandom; word_count = 26'd3;
    writes = 0; guard = 0;
    while (writes < 2 && guard < 20) begin
      @(negedge clock); #1;
      start = 1'b0;
      guard++;
      mem_ready = 1'b1;
      if (mem_we) begin
        writes++;
        if (writes == 2) mem_ready = 1'b0;
      end
    end
    chk("second_write_reached", writes, 2);
    #2 reset = 1'b0;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_disk_addr", disk_addr, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    run_load($urandom, 26'd1, 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0;
    mem_base = '0; word_count = '0;
    fill_disk(-1);
    #1;
    chk("reset_we", mem_we, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_words", words_loaded, 0);
    chk("reset_disk_addr", disk_addr, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    run_load(26'd100, 26'd3, 0);
    fill_disk(15);
    run_load($urandom, 26'd100, 0);
    fill_disk(-1);
    run_load($urandom, 26'd5, 1);
    run_load($urandom, 26'd0, 0);
    run_load(26'h3FF_FFFF, 26'd2, 0);
    for (int t = 0; t < 10; t++) begin
      fill_disk($urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 15)));
      run_load($urandom, 26'($urandom_range(0, 20)), 2);
    end
    reset_mid_load();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
